// File: rtl/mdio_mmd_slave.sv
// MDIO slave front end for Clause 22 / Clause 45 frames, clocked entirely by mdc.
// Decodes management frames on mdi, serves reads on mdo/mdo_en and strobes a PHY register bank.
module mdio_mmd_slave #(
  parameter int          MODE         = 2,
  parameter int          PREAMBLE_LEN = 32,
  parameter logic [31:0] MMD_MASK     = 32'hFFFF_FFFE
) (
  input  logic        mdc,
  input  logic        rst_n,
  input  logic        mdi,
  output logic        mdo,
  output logic        mdo_en,
  input  logic [4:0]  phy_addr,
  output logic        reg_wr,
  output logic        reg_rd,
  output logic [4:0]  reg_dev,
  output logic [15:0] reg_addr,
  output logic [15:0] reg_wdata,
  input  logic [15:0] reg_rdata,
  output logic        frame_err
);

  localparam logic [5:0] PRE_LEN = 6'(PREAMBLE_LEN);
  localparam bit         C22_OK  = (MODE != 1);
  localparam bit         C45_OK  = (MODE != 0);

  typedef enum logic [3:0] {
    S_PRE, S_ST, S_OP, S_PAD, S_RAD, S_TA1, S_TA2, S_WDAT, S_RDAT, S_SKIP
  } state_t;

  typedef enum logic [1:0] {OP_ADDR, OP_WRITE, OP_READ, OP_RINC} op_t;

  state_t      state;
  op_t         op;
  logic [5:0]  pre_cnt;
  logic [4:0]  bit_cnt;
  logic        is_c22;
  logic        ta_hi;
  logic [4:0]  pad;
  logic [15:0] shift;
  logic [15:0] addr_reg;

  logic [1:0]  op_bits;
  logic [4:0]  rad_val;
  logic [15:0] wdat;
  logic        addressed;
  logic        is_read;

  assign op_bits   = {shift[0], mdi};
  assign rad_val   = {shift[3:0], mdi};
  assign wdat      = {shift[14:0], mdi};
  assign addressed = (pad == phy_addr) && (is_c22 || MMD_MASK[rad_val]);
  assign is_read   = (op == OP_READ) || (op == OP_RINC);

  // One shift register serves OP/PAD/RAD/write-data collection and read-data serialisation.
  always_ff @(posedge mdc) begin
    if (!rst_n) begin
      state     <= S_PRE;
      op        <= OP_ADDR;
      pre_cnt   <= '0;
      bit_cnt   <= '0;
      is_c22    <= 1'b0;
      ta_hi     <= 1'b0;
      pad       <= '0;
      shift     <= '0;
      addr_reg  <= '0;
      mdo       <= 1'b0;
      mdo_en    <= 1'b0;
      reg_wr    <= 1'b0;
      reg_rd    <= 1'b0;
      frame_err <= 1'b0;
      reg_dev   <= '0;
      reg_addr  <= '0;
      reg_wdata <= '0;
    end else begin
      reg_wr    <= 1'b0;
      reg_rd    <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        S_PRE: begin
          if (mdi) begin
            if (pre_cnt != 6'd32) pre_cnt <= pre_cnt + 6'd1;
          end else begin
            pre_cnt <= '0;
            if (pre_cnt >= PRE_LEN) state <= S_ST;
          end
        end
        S_ST: begin
          if (mdi ? C22_OK : C45_OK) begin
            is_c22  <= mdi;
            bit_cnt <= '0;
            state   <= S_OP;
          end else begin
            state <= S_PRE;
          end
        end
        S_OP: begin
          shift <= {shift[14:0], mdi};
          if (bit_cnt == 5'd1) begin
            bit_cnt <= '0;
            state   <= S_PAD;
            if (is_c22) begin
              case (op_bits)
                2'b01:   op <= OP_WRITE;
                2'b10:   op <= OP_READ;
                default: begin
                  frame_err <= 1'b1;
                  bit_cnt   <= 5'd27;
                  state     <= S_SKIP;
                end
              endcase
            end else begin
              case (op_bits)
                2'b00:   op <= OP_ADDR;
                2'b01:   op <= OP_WRITE;
                2'b11:   op <= OP_READ;
                default: op <= OP_RINC;
              endcase
            end
          end else begin
            bit_cnt <= bit_cnt + 5'd1;
          end
        end
        S_PAD: begin
          shift <= {shift[14:0], mdi};
          if (bit_cnt == 5'd4) begin
            pad     <= rad_val;
            bit_cnt <= '0;
            state   <= S_RAD;
          end else begin
            bit_cnt <= bit_cnt + 5'd1;
          end
        end
        S_RAD: begin
          shift <= {shift[14:0], mdi};
          if (bit_cnt == 5'd4) begin
            if (!addressed) begin
              bit_cnt <= 5'd17;
              state   <= S_SKIP;
            end else begin
              reg_dev  <= is_c22 ? 5'd0 : rad_val;
              reg_addr <= is_c22 ? {11'b0, rad_val} : addr_reg;
              reg_rd   <= is_read;
              state    <= S_TA1;
            end
          end else begin
            bit_cnt <= bit_cnt + 5'd1;
          end
        end
        S_TA1: begin
          ta_hi <= mdi;
          state <= S_TA2;
          if (is_read) begin
            shift  <= reg_rdata;
            mdo_en <= 1'b1;
            mdo    <= 1'b0;
            if (op == OP_RINC) addr_reg <= addr_reg + 16'd1;
          end
        end
        S_TA2: begin
          bit_cnt <= '0;
          if (is_read) begin
            mdo   <= shift[15];
            shift <= {shift[14:0], 1'b0};
            state <= S_RDAT;
          end else if (ta_hi && !mdi) begin
            state <= S_WDAT;
          end else begin
            frame_err <= 1'b1;
            bit_cnt   <= 5'd15;
            state     <= S_SKIP;
          end
        end
        S_WDAT: begin
          shift <= {shift[14:0], mdi};
          if (bit_cnt == 5'd15) begin
            state <= S_PRE;
            if (op == OP_ADDR) begin
              addr_reg <= wdat;
            end else begin
              reg_wr    <= 1'b1;
              reg_wdata <= wdat;
            end
          end else begin
            bit_cnt <= bit_cnt + 5'd1;
          end
        end
        S_RDAT: begin
          if (bit_cnt == 5'd15) begin
            mdo_en <= 1'b0;
            mdo    <= 1'b0;
            state  <= S_PRE;
          end else begin
            mdo     <= shift[15];
            shift   <= {shift[14:0], 1'b0};
            bit_cnt <= bit_cnt + 5'd1;
          end
        end
        S_SKIP: begin
          if (bit_cnt == 5'd0) state <= S_PRE;
          else bit_cnt <= bit_cnt - 5'd1;
        end
        default: state <= S_PRE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdio_mmd_slave.sv
// Directed bench for mdio_mmd_slave: serial frames driven on the falling edge,
// outputs sampled 1 time unit after each rising edge and compared with hand-derived values.
module tb_mdio_mmd_slave;

  logic        mdc = 1'b0;
  logic        rst_n = 1'b0;
  logic        mdi = 1'b1;
  logic        mdo;
  logic        mdo_en;
  logic [4:0]  phy_addr = 5'h03;
  logic        reg_wr;
  logic        reg_rd;
  logic [4:0]  reg_dev;
  logic [15:0] reg_addr;
  logic [15:0] reg_wdata;
  logic [15:0] reg_rdata = 16'h0000;
  logic        frame_err;

  int checks = 0;
  int failures = 0;

  int          bit_idx, wr_cnt, rd_cnt, err_cnt, en_cnt, en_first, rd_idx, err_idx;
  logic [15:0] wr_data, wr_addr, rd_addr;
  logic [4:0]  wr_dev, rd_dev;
  logic [31:0] mdo_seq;

  mdio_mmd_slave dut (
    .mdc       (mdc),
    .rst_n     (rst_n),
    .mdi       (mdi),
    .mdo       (mdo),
    .mdo_en    (mdo_en),
    .phy_addr  (phy_addr),
    .reg_wr    (reg_wr),
    .reg_rd    (reg_rd),
    .reg_dev   (reg_dev),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_rdata (reg_rdata),
    .frame_err (frame_err)
  );

  always #5 mdc = ~mdc;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clearStats();
    bit_idx = 0; wr_cnt = 0; rd_cnt = 0; err_cnt = 0; en_cnt = 0;
    en_first = 0; rd_idx = 0; err_idx = 0;
    wr_data = '0; wr_addr = '0; rd_addr = '0; wr_dev = '0; rd_dev = '0;
    mdo_seq = '0;
  endtask

  // Drive one bit for a full mdc period, then log whatever the DUT produced at that edge.
  task automatic applyStimulus(input logic b);
    @(negedge mdc);
    mdi = b;
    @(posedge mdc);
    #1;
    bit_idx++;
    if (reg_wr) begin
      wr_cnt++; wr_data = reg_wdata; wr_addr = reg_addr; wr_dev = reg_dev;
    end
    if (reg_rd) begin
      rd_cnt++; rd_idx = bit_idx; rd_addr = reg_addr; rd_dev = reg_dev;
    end
    if (frame_err) begin
      err_cnt++; err_idx = bit_idx;
    end
    if (mdo_en) begin
      en_cnt++;
      if (en_first == 0) en_first = bit_idx;
      mdo_seq = {mdo_seq[30:0], mdo};
    end
  endtask

  // Frame bits are numbered 1..32 after the preamble: ST 1-2, OP 3-4, PAD 5-9, RAD 10-14, TA 15-16, data 17-32.
  task automatic sendFrame(input int pre_len, input logic [1:0] st, input logic [1:0] op,
                           input logic [4:0] pad, input logic [4:0] rad, input logic [1:0] ta,
                           input logic [15:0] data, input int rst_at);
    logic [31:0] frame;
    logic stop;
    frame = {st, op, pad, rad, ta, data};
    stop = 1'b0;
    clearStats();
    for (int i = 0; i < pre_len; i++) applyStimulus(1'b1);
    bit_idx = 0;
    for (int i = 31; i >= 0 && !stop; i--) begin
      if (32 - i == rst_at) begin
        rst_n = 1'b0;
        stop = 1'b1;
      end
      applyStimulus(frame[i]);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    clearStats();
    rst_n = 1'b0;
    repeat (3) applyStimulus(1'b1);
    checkOutput("rst_ctrl", 32'({mdo, mdo_en, reg_wr, reg_rd, frame_err, reg_dev}), 32'h0);
    checkOutput("rst_data", {reg_addr, reg_wdata}, 32'h0);
    rst_n = 1'b1;

    // C22 write PHY 3 REG 4 data A5C3
    sendFrame(32, 2'b01, 2'b01, 5'h03, 5'h04, 2'b10, 16'hA5C3, 0);
    checkOutput("t1_wr_cnt", 32'(wr_cnt), 32'd1);
    checkOutput("t1_wdata", 32'(wr_data), 32'h0000_A5C3);
    checkOutput("t1_addr", 32'(wr_addr), 32'h0000_0004);
    checkOutput("t1_dev", 32'(wr_dev), 32'h0);
    checkOutput("t1_en_cnt", 32'(en_cnt), 32'd0);
    checkOutput("t1_rd_err", 32'(rd_cnt + err_cnt), 32'd0);

    // C22 read addressed to PHY 7: must be skipped silently
    reg_rdata = 16'h0141;
    sendFrame(32, 2'b01, 2'b10, 5'h07, 5'h02, 2'b11, 16'hFFFF, 0);
    checkOutput("t3_rd_cnt", 32'(rd_cnt), 32'd0);
    checkOutput("t3_en_cnt", 32'(en_cnt), 32'd0);
    checkOutput("t3_wr_err", 32'(wr_cnt + err_cnt), 32'd0);

    // C22 read REG 2 straight after the skipped frame (tests return to PRE)
    sendFrame(32, 2'b01, 2'b10, 5'h03, 5'h02, 2'b11, 16'hFFFF, 0);
    checkOutput("t2_rd_cnt", 32'(rd_cnt), 32'd1);
    checkOutput("t2_rd_idx", 32'(rd_idx), 32'd14);
    checkOutput("t2_rd_addr", 32'(rd_addr), 32'h0000_0002);
    checkOutput("t2_en_first", 32'(en_first), 32'd15);
    checkOutput("t2_en_cnt", 32'(en_cnt), 32'd17);
    checkOutput("t2_mdo_seq", 32'(mdo_seq[16:0]), 32'h0000_0141);
    checkOutput("t2_en_end", 32'(mdo_en), 32'd0);

    // C45 address frame DEVAD 1 -> FFFF, then two read-post-increment frames
    reg_rdata = 16'h1234;
    sendFrame(32, 2'b00, 2'b00, 5'h03, 5'h01, 2'b10, 16'hFFFF, 0);
    checkOutput("t4_addr_strobes", 32'(wr_cnt + rd_cnt + err_cnt), 32'd0);
    sendFrame(32, 2'b00, 2'b10, 5'h03, 5'h01, 2'b11, 16'hFFFF, 0);
    checkOutput("t4a_rd_cnt", 32'(rd_cnt), 32'd1);
    checkOutput("t4a_rd_addr", 32'(rd_addr), 32'h0000_FFFF);
    checkOutput("t4a_rd_dev", 32'(rd_dev), 32'd1);
    checkOutput("t4a_mdo_seq", 32'(mdo_seq[16:0]), 32'h0000_1234);
    sendFrame(32, 2'b00, 2'b10, 5'h03, 5'h01, 2'b11, 16'hFFFF, 0);
    checkOutput("t4b_rd_addr", 32'(rd_addr), 32'h0000_0000);
    checkOutput("t4b_mdo_seq", 32'(mdo_seq[16:0]), 32'h0000_1234);
    // DEVAD 0 is masked off
    sendFrame(32, 2'b00, 2'b11, 5'h03, 5'h00, 2'b11, 16'hFFFF, 0);
    checkOutput("t4c_masked", 32'(rd_cnt + en_cnt), 32'd0);
    // C45 write uses the twice-incremented address 0001
    sendFrame(32, 2'b00, 2'b01, 5'h03, 5'h01, 2'b10, 16'hBEEF, 0);
    checkOutput("t4d_wr_cnt", 32'(wr_cnt), 32'd1);
    checkOutput("t4d_wr_addr", 32'(wr_addr), 32'h0000_0001);
    checkOutput("t4d_wr_dev", 32'(wr_dev), 32'd1);
    checkOutput("t4d_wdata", 32'(wr_data), 32'h0000_BEEF);

    // Short preamble ignored, then bad turnaround
    sendFrame(31, 2'b01, 2'b01, 5'h03, 5'h04, 2'b10, 16'hA5C3, 0);
    checkOutput("t5a_ignored", 32'(wr_cnt + err_cnt), 32'd0);
    sendFrame(32, 2'b01, 2'b01, 5'h03, 5'h04, 2'b11, 16'h5A5A, 0);
    checkOutput("t5b_err_cnt", 32'(err_cnt), 32'd1);
    checkOutput("t5b_err_idx", 32'(err_idx), 32'd16);
    checkOutput("t5b_wr_cnt", 32'(wr_cnt), 32'd0);

    // Reset during D7 of a read (D8=1, D7=1 so mdo is high before the reset)
    reg_rdata = 16'h0180;
    sendFrame(32, 2'b01, 2'b10, 5'h03, 5'h02, 2'b11, 16'hFFFF, 25);
    checkOutput("t6_pre_bits", 32'(mdo_seq[9:0]), 32'h0000_0003);
    checkOutput("t6_en_cnt", 32'(en_cnt), 32'd10);
    checkOutput("t6_rst_outs", 32'({mdo, mdo_en, reg_wr, reg_rd, frame_err}), 32'h0);
    rst_n = 1'b1;
    reg_rdata = 16'h0141;
    sendFrame(32, 2'b01, 2'b10, 5'h03, 5'h02, 2'b11, 16'hFFFF, 0);
    checkOutput("t6_rd_cnt", 32'(rd_cnt), 32'd1);
    checkOutput("t6_mdo_seq", 32'(mdo_seq[16:0]), 32'h0000_0141);
    checkOutput("t6_en_cnt2", 32'(en_cnt), 32'd17);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
